// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: IR, memory handshake sequencing, traps.
// Define CONTROLLER_MISALIGN_TRAP_EN to trap misaligned loads/stores.
module multicycle_controller #(
  parameter int TIMEOUT   = 15,
  parameter int TIMEOUT_W = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memRdata,
  input  logic        memReady,
  input  logic [31:0] memAddr,
  input  logic        ALUZero,
  output logic [31:0] instruction,
  output logic        memReq,
  output logic        memWe,
  output logic        irWr,
  output logic        pcWr,
  output logic        regWr,
  output logic [3:0]  ALUCtrl,
  output logic        ALUImm,
  output logic        ALUToPC,
  output logic        branch,
  output logic        memToReg,
  output logic        rs2ShiftSel,
  output logic        uext,
  output logic [1:0]  loadSel,
  output logic [1:0]  maskSel,
  output logic [1:0]  regDataSel,
  output logic        trap,
  output logic [3:0]  trapCause,
  output logic [2:0]  state
);

  localparam int CW = (TIMEOUT_W < 1) ? 1 : TIMEOUT_W;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  localparam bit TMO_EN = (TIMEOUT != 0);

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_BR    = 5'b11000;
  localparam logic [4:0] OP_LD    = 5'b00000;
  localparam logic [4:0] OP_ST    = 5'b01000;
  localparam logic [4:0] OP_IMM   = 5'b00100;
  localparam logic [4:0] OP_REG   = 5'b01100;
  localparam logic [4:0] OP_FENCE = 5'b00011;
  localparam logic [4:0] OP_SYS   = 5'b11100;

  localparam logic [3:0] A_ADD  = 4'b0000;
  localparam logic [3:0] A_SUB  = 4'b0001;
  localparam logic [3:0] A_AND  = 4'b0010;
  localparam logic [3:0] A_OR   = 4'b0011;
  localparam logic [3:0] A_XOR  = 4'b0100;
  localparam logic [3:0] A_SLL  = 4'b0101;
  localparam logic [3:0] A_SRL  = 4'b0110;
  localparam logic [3:0] A_SRA  = 4'b0111;
  localparam logic [3:0] A_SLT  = 4'b1000;
  localparam logic [3:0] A_SLTU = 4'b1001;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t st, nxt;
  logic [31:0] ir;
  logic [CW-1:0] cnt;
  logic [3:0] cause, ncause;

  logic [4:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_ld, is_st, is_opi;
  logic is_op, is_fence, is_sys;
  logic illegal, misal, tmo, taken;

  assign op = ir[6:2];
  assign f3 = ir[14:12];
  assign f7 = ir[31:25];

  assign is_lui   = (op == OP_LUI);
  assign is_auipc = (op == OP_AUIPC);
  assign is_jal   = (op == OP_JAL);
  assign is_jalr  = (op == OP_JALR);
  assign is_br    = (op == OP_BR);
  assign is_ld    = (op == OP_LD);
  assign is_st    = (op == OP_ST);
  assign is_opi   = (op == OP_IMM);
  assign is_op    = (op == OP_REG);
  assign is_fence = (op == OP_FENCE);
  assign is_sys   = (op == OP_SYS);

  always_comb begin
    illegal = 1'b0;
    if (ir[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      unique case (1'b1)
        is_op:
          illegal = !((f7 == 7'h00) ||
                      ((f7 == 7'h20) &&
                       ((f3 == 3'b000) ||
                        (f3 == 3'b101))));
        is_ld:
          illegal = (f3 == 3'b011) ||
                    (f3[2:1] == 2'b11);
        is_st:
          illegal = (f3 >= 3'b011);
        is_br:
          illegal = (f3[2:1] == 2'b01);
        is_sys:
          illegal = (ir != ECALL) &&
                    (ir != EBREAK);
        is_lui, is_auipc, is_jal,
        is_jalr, is_opi, is_fence:
          illegal = 1'b0;
        default:
          illegal = 1'b1;
      endcase
    end
  end

`ifdef CONTROLLER_MISALIGN_TRAP_EN
  logic unused_addr;
  assign unused_addr = ^memAddr[31:2];
  always_comb begin
    misal = 1'b0;
    unique case (f3[1:0])
      2'b01:   misal = memAddr[0];
      2'b10:   misal = |memAddr[1:0];
      default: misal = 1'b0;
    endcase
  end
`else
  logic unused_addr;
  assign unused_addr = ^memAddr;
  assign misal = 1'b0;
`endif

  always_comb begin
    ALUCtrl = A_ADD;
    if (is_op || is_opi) begin
      unique case (f3)
        3'b000: ALUCtrl = (is_op && f7[5]) ? A_SUB : A_ADD;
        3'b001: ALUCtrl = A_SLL;
        3'b010: ALUCtrl = A_SLT;
        3'b011: ALUCtrl = A_SLTU;
        3'b100: ALUCtrl = A_XOR;
        3'b101: ALUCtrl = f7[5] ? A_SRA : A_SRL;
        3'b110: ALUCtrl = A_OR;
        3'b111: ALUCtrl = A_AND;
        default: ALUCtrl = A_ADD;
      endcase
    end else if (is_br) begin
      unique case (f3[2:1])
        2'b10:   ALUCtrl = A_SLT;
        2'b11:   ALUCtrl = A_SLTU;
        default: ALUCtrl = A_SUB;
      endcase
    end
  end

  // BEQ/BGE/BGEU take on zero; BNE/BLT/BLTU on non-zero
  assign taken = (f3[2] ^ f3[0]) ? ~ALUZero : ALUZero;

  assign ALUImm = is_opi | is_ld | is_st | is_jalr |
                  is_lui | is_auipc;
  assign memToReg    = is_ld;
  assign loadSel     = f3[1:0];
  assign maskSel     = f3[1:0];
  assign uext        = f3[2];
  assign rs2ShiftSel = f3[0];

  always_comb begin
    regDataSel = 2'b00;
    unique case (1'b1)
      is_lui:           regDataSel = 2'b01;
      is_auipc:         regDataSel = 2'b10;
      is_jal, is_jalr:  regDataSel = 2'b11;
      default:          regDataSel = 2'b00;
    endcase
  end

  assign tmo = TMO_EN && (cnt == TMAX);

  always_comb begin
    nxt     = st;
    ncause  = cause;
    memReq  = 1'b0;
    memWe   = 1'b0;
    irWr    = 1'b0;
    pcWr    = 1'b0;
    regWr   = 1'b0;
    branch  = 1'b0;
    ALUToPC = 1'b0;
    unique case (st)
      S_FETCH: begin
        memReq = 1'b1;
        if (memReady) begin
          irWr = 1'b1;
          nxt  = S_DECODE;
        end else if (tmo) begin
          nxt    = S_TRAP;
          ncause = 4'd1;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          nxt    = S_TRAP;
          ncause = 4'd2;
        end else if (ir == ECALL) begin
          nxt    = S_TRAP;
          ncause = 4'd11;
        end else if (ir == EBREAK) begin
          nxt    = S_TRAP;
          ncause = 4'd3;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          is_br: begin
            pcWr   = 1'b1;
            branch = taken;
            nxt    = S_FETCH;
          end
          is_fence: begin
            pcWr = 1'b1;
            nxt  = S_FETCH;
          end
          is_ld, is_st: begin
            if (misal) begin
              nxt    = S_TRAP;
              ncause = is_st ? 4'd6 : 4'd4;
            end else begin
              nxt = S_MEM;
            end
          end
          default: nxt = S_WB;
        endcase
      end
      S_MEM: begin
        memReq = 1'b1;
        memWe  = is_st;
        if (memReady) begin
          pcWr = is_st;
          nxt  = is_st ? S_FETCH : S_WB;
        end else if (tmo) begin
          nxt    = S_TRAP;
          ncause = is_st ? 4'd7 : 4'd5;
        end
      end
      S_WB: begin
        regWr   = 1'b1;
        pcWr    = 1'b1;
        branch  = is_jal | is_jalr;
        ALUToPC = is_jalr;
        nxt     = S_FETCH;
      end
      S_TRAP: nxt = S_TRAP;
      default: nxt = S_FETCH;
    endcase
    // reset aborts any in-flight request with no side effects
    if (reset) begin
      memReq = 1'b0;
      memWe  = 1'b0;
      irWr   = 1'b0;
      pcWr   = 1'b0;
      regWr  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= S_FETCH;
      ir    <= NOP;
      cnt   <= '0;
      cause <= 4'd0;
    end else begin
      st    <= nxt;
      cause <= ncause;
      cnt   <= (memReq && !memReady) ? cnt + 1'b1 : '0;
      if (irWr) ir <= memRdata;
    end
  end

  assign instruction = ir;
  assign trap        = (st == S_TRAP);
  assign trapCause   = cause;
  assign state       = st;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control unit for the RV32I core. It replaces the purely combinational decoder with a state machine that sequences fetch, decode, execute, memory and write-back phases over a shared memory port with a request/ready handshake. It also holds the instruction register and raises precise traps for illegal encodings, ECALL/EBREAK, misaligned accesses and memory timeouts. It sits between the memory interface and the datapath (ALU, register file, PC register).

## Interface
Parameters:
- TIMEOUT, default 15: maximum wait cycles for memReady per memory request; 0 disables the timeout.
- TIMEOUT_W, default $clog2(TIMEOUT+1): width of the wait counter; derived, not overridden.

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- memRdata  in  32  memory read data; latched into IR on a fetch handshake.
- memReady  in  1  memory completes the current request this cycle.
- memAddr  in  32  ALU result (effective address), used for the misalignment check.
- ALUZero  in  1  ALU zero flag.
- instruction  out  32  current IR contents.
- memReq  out  1  memory request active.
- memWe  out  1  write qualifier; valid only while memReq is high.
- irWr, pcWr, regWr  out  1 each  single-cycle write strobes.
- ALUCtrl  out  4  ALU operation.
- ALUImm, ALUToPC, branch, memToReg, rs2ShiftSel, uext  out  1 each  datapath selects.
- loadSel, maskSel, regDataSel  out  2 each  datapath selects.
- trap  out  1  core halted on a trap.
- trapCause  out  4  RISC-V mcause code of the trap.
- state  out  3  current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Datapath selects are decoded combinationally from IR. Encoding:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
  - loadSel and maskSel = funct3[1:0]; uext = funct3[2]; rs2ShiftSel = funct3[0].
  - regDataSel: 01 LUI, 10 AUIPC, 11 JAL/JALR.
- FETCH: memReq=1, memWe=0. On memReady: IR<=memRdata, irWr=1, go to DECODE.
- DECODE: one cycle. Trap checks, in priority order:
  - Illegal → cause 2. Illegal means any of:
    - opcode[1:0]≠11;
    - unknown opcode[6:2];
    - R-type funct7 not 0x00 or 0x20, or 0x20 with funct3 other than 000/101;
    - load funct3 011/110/111;
    - store funct3 ≥011;
    - branch funct3 010/011;
    - SYSTEM other than the exact ECALL/EBREAK words.
  - ECALL (0x00000073) → cause 11.
  - EBREAK (0x00100073) → cause 3.
  - Otherwise go to EXEC.
- EXEC:
  - B-type: branch=condition (BEQ/BGE/BGEU taken on ALUZero; BNE/BLT/BLTU taken on ~ALUZero); pcWr=1; go to FETCH.
  - FENCE: pcWr=1, branch=0; go to FETCH.
  - Load/store: go to MEM.
  - All other classes: go to WB.
- MEM: memReq=1, memWe=1 for stores.
  - On memReady, store: pcWr=1, go to FETCH.
  - On memReady, load: go to WB.
- WB: regWr=1 and pcWr=1 for one cycle.
  - JAL and JALR also set branch=1 (JALR also sets ALUToPC=1).
  - Go to FETCH.
- TRAP: trap=1 and trapCause held. All strobes and memReq are 0. The block leaves TRAP only on reset.
- pcWr pulses exactly once per retired instruction. Trapped instructions never assert pcWr, regWr or memWe.
- Wait counter:
  - Clears on entry to FETCH or MEM and on each handshake.
  - Increments each memReq cycle without memReady.
  - When the counter equals TIMEOUT with memReady still low: go to TRAP with cause 1 (fetch) or cause 5 (load) / 7 (store).
  - memReady in that same cycle wins over the timeout.

## Timing
- Reset values:
  - state=FETCH, IR=0x00000013 (NOP), counter=0.
  - trap=0, trapCause=0.
  - memReq, memWe, irWr, pcWr, regWr = 0.
- Reset asserted mid-operation (including during TRAP or MEM) aborts the request without any write strobe. memReq is asserted again in the first cycle after reset deasserts.
- Latency with zero-wait memory (memReady in the first request cycle), in cycles per instruction: branch/FENCE 3; ALU/U/J 4; store 4; load 5. Each wait cycle adds 1.
- memReq stays high continuously until a handshake or a timeout. memWe is stable for the whole request.

## Configuration
- CONTROLLER_MISALIGN_TRAP_EN defined:
  - In EXEC, a load/store with memAddr misaligned for its width goes to TRAP instead of MEM.
  - Misaligned means halfword with memAddr[0]≠0, or word with memAddr[1:0]≠00.
  - Causes: 4 for loads, 6 for stores.
- Undefined: no alignment check; the access is issued unchanged.

## Test plan
- ADDI x1,x0,5 (0x00500093) with zero-wait memory → irWr in cycle 1, regWr and pcWr together in cycle 4, ALUCtrl=0000, ALUImm=1; back to FETCH.
- LW (0x0000A103) with memReady delayed 3 cycles in MEM → memReq high continuously for 4 cycles, then WB with memToReg=1; 8 cycles total.
- BNE with ALUZero=0, then again with ALUZero=1 → EXEC asserts pcWr with branch=1, then pcWr with branch=0; regWr never asserted.
- Memory never ready, TIMEOUT=15 → TRAP after 16 request cycles with trapCause=1; a reset pulse returns the block to FETCH with IR=0x00000013.
- Word 0xFFFFFFFF → TRAP cause 2. 0x00000073 → cause 11. 0x00100073 → cause 3. None of these assert pcWr.
- SW with memAddr=0x102 and the macro defined → TRAP cause 6, memWe never high. With the macro undefined → the store completes and pcWr pulses.
